// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the BCD frequency meter.
package freq_meter_pkg;

   typedef enum logic {
      IDLE,
      GATE
   } state_t;

   typedef enum logic [1:0] {
      RANGE_X1   = 2'd0,
      RANGE_X10  = 2'd1,
      RANGE_X100 = 2'd2
   } range_t;

   typedef logic [3:0] bcd_digit_t;

   // Range code 3 has no window of its own and behaves as the shortest range.
   function automatic logic [1:0] norm_range(input logic [1:0] r);
      return (r == 2'd3) ? 2'd2 : r;
   endfunction

   function automatic int range_divisor(input logic [1:0] r);
      case (norm_range(r))
         RANGE_X1:  return 1;
         RANGE_X10: return 10;
         default:   return 100;
      endcase
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter with sticky overflow.
module bcd_counter
   import freq_meter_pkg::*;
#(
   parameter int DIGITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
   output logic [4*DIGITS-1:0] count,
   output logic                ovf,
   output logic [4*DIGITS-1:0] next_count
);

   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] ripple;
   logic                ovf_q;
   logic                sat;

   // Ripple-carry BCD increment; a carry out of the top digit means saturation.
   always_comb begin
      bcd_digit_t d;
      logic       carry;
      ripple = count_q;
      carry  = inc;
      d      = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = count_q[4*i +: 4];
         if (carry) begin
            if (d == 4'd9) begin
               ripple[4*i +: 4] = 4'd0;
            end else begin
               ripple[4*i +: 4] = d + 4'd1;
               carry            = 1'b0;
            end
         end
      end
      sat        = carry;
      next_count = carry ? count_q : ripple;
   end

   // Count register; clear wins over increment so a window reload drops the old total.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (inc) begin
         count_q <= next_count;
         ovf_q   <= ovf_q | sat;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/bcd_freq_meter.sv
// Self-gated frequency meter: synchronised edge count per window, reported as BCD.
module bcd_freq_meter
   import freq_meter_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int GATE_CYCLES = 50_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sig_in,
   input  logic                enable,
   input  logic [1:0]          range,
   output logic [4*DIGITS-1:0] bcd,
   output logic                valid,
   output logic                overflow,
   output logic [1:0]          range_used
);

   localparam int GW       = $clog2(GATE_CYCLES + 1);
   localparam int LEN_X1_I   = GATE_CYCLES / range_divisor(RANGE_X1);
   localparam int LEN_X10_I  = GATE_CYCLES / range_divisor(RANGE_X10);
   localparam int LEN_X100_I = GATE_CYCLES / range_divisor(RANGE_X100);
   localparam logic [GW-1:0] LEN_X1   = LEN_X1_I[GW-1:0];
   localparam logic [GW-1:0] LEN_X10  = LEN_X10_I[GW-1:0];
   localparam logic [GW-1:0] LEN_X100 = LEN_X100_I[GW-1:0];
   localparam logic [GW-1:0] GATE_ONE = {{(GW-1){1'b0}}, 1'b1};

   if (GATE_CYCLES < 100 || (GATE_CYCLES % 100) != 0) begin : g_bad_gate
      $error("GATE_CYCLES must be a positive multiple of 100");
   end
   if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
      $error("DIGITS must be in 1..10");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end

   state_t                 state_q;
   logic [GW-1:0]          gate_q;
   logic [1:0]             range_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [4*DIGITS-1:0]    bcd_q;
   logic                   valid_q;
   logic                   overflow_q;
   logic [1:0]             range_used_q;

   logic [4*DIGITS-1:0]    count;
   logic [4*DIGITS-1:0]    next_count;
   logic                   ovf;
   logic                   sig_rise;
   logic                   in_gate;
   logic                   terminal;
   logic                   cnt_inc;
   logic                   cnt_clr;
   logic                   sat_now;
   logic [GW-1:0]          load_len_d;
   logic [1:0]             load_range_d;

   // Window length and reported range for a load, taken from the live range input.
   always_comb begin
      load_range_d = norm_range(range);
      case (load_range_d)
         RANGE_X1:  load_len_d = LEN_X1;
         RANGE_X10: load_len_d = LEN_X10;
         default:   load_len_d = LEN_X100;
      endcase
   end

   // Synchroniser chain plus one delay flop for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign in_gate  = (state_q == GATE);
   assign terminal = in_gate && (gate_q == GATE_ONE);
   assign cnt_inc  = in_gate & sig_rise;
   assign cnt_clr  = !in_gate || terminal;
   // A saturated increment leaves the count unchanged, which flags this cycle's overflow.
   assign sat_now  = cnt_inc && (next_count == count);

   bcd_counter #(
      .DIGITS (DIGITS)
   ) u_count (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr),
      .inc        (cnt_inc),
      .count      (count),
      .ovf        (ovf),
      .next_count (next_count)
   );

   // Gate FSM with result latch; windows abut because the terminal cycle reloads directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gate_q       <= '0;
         range_q      <= 2'd0;
         bcd_q        <= '0;
         valid_q      <= 1'b0;
         overflow_q   <= 1'b0;
         range_used_q <= 2'd0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  gate_q  <= load_len_d;
                  range_q <= load_range_d;
                  state_q <= GATE;
               end else begin
                  gate_q <= '0;
               end
            end
            GATE: begin
               if (terminal) begin
                  bcd_q        <= next_count;
                  overflow_q   <= ovf | sat_now;
                  range_used_q <= range_q;
                  valid_q      <= 1'b1;
                  if (enable) begin
                     gate_q  <= load_len_d;
                     range_q <= load_range_d;
                  end else begin
                     gate_q  <= '0;
                     state_q <= IDLE;
                  end
               end else if (!enable) begin
                  gate_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  gate_q <= gate_q - GATE_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bcd        = bcd_q;
   assign valid      = valid_q;
   assign overflow   = overflow_q;
   assign range_used = range_used_q;

endmodule

// File: doc/bcd_freq_meter.md
# bcd_freq_meter

Parametrised, single-clock frequency counter. It counts rising edges of an asynchronous input over a self-timed gate window and presents the result as packed BCD digits for the display path. It succeeds the gated BCD counter and adds the following: an internal gate generator with three decade ranges, a configurable digit count, input synchronisation, a valid strobe, saturation with overflow flagging, and zero dead time between windows.

## Interface
- DIGITS, 8, number of BCD digits in the result (1..10)
- GATE_CYCLES, 50_000_000, clk cycles in the range-0 gate window; must be a multiple of 100 (elaboration-time check)
- SYNC_STAGES, 2, synchroniser flops on sig_in (>=2)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sig_in  in  1  measured signal, asynchronous to clk
- enable  in  1  1 = measure continuously; 0 = idle
- range  in  2  gate select: 0 = GATE_CYCLES, 1 = GATE_CYCLES/10, 2 = GATE_CYCLES/100, 3 = treated as 2
- bcd  out  4*DIGITS  last completed count; digit 0 in bits [3:0]
- valid  out  1  one-cycle strobe when bcd/overflow/range_used update
- overflow  out  1  last window exceeded 10^DIGITS-1 edges
- range_used  out  2  range that produced the current bcd (3 is reported as 2)

## Operation
- sig_in passes through SYNC_STAGES flops, then a one-flop edge detector: edge = sync_last & ~prev.
- FSM states: IDLE, GATE.
  - IDLE: count and gate counter held at 0. When enable=1, sample range, load gate counter with the window length L, clear the count, and go to GATE.
  - GATE: on each cycle, if edge, increment the BCD count; decrement the gate counter.
  - Terminal cycle (gate counter == 1): latch bcd <= count including this cycle's edge; overflow <= sticky ovf; range_used <= sampled range; valid <= 1 on the next cycle.
  - After the terminal cycle: if enable=1, reload L from the current range, clear the count and ovf, and stay in GATE. Otherwise go to IDLE.
  - Consecutive windows abut. Every edge is counted in exactly one window.
- BCD increment is a ripple-carry over the digits: digit 9 becomes 0 and carries. When all digits are 9 and an edge arrives, the count stays at all-9s (saturated) and ovf is set; ovf is sticky for the window.
- enable=0 during GATE aborts the window: go to IDLE, no valid, and outputs keep their previous values.
- A range change during GATE is ignored until the next window load.

## Timing
- Reset values: bcd=0, valid=0, overflow=0, range_used=0, state=IDLE, synchroniser/edge flops=0, count=0, gate counter=0.
- Edge latency: a sig_in rising edge is counted SYNC_STAGES+1 cycles after it reaches the first synchroniser flop.
- Window: exactly L cycles. valid is high in the cycle after the terminal cycle. bcd, overflow and range_used change only in the cycle valid rises, and hold until the next valid.
- First valid after enable rises (from IDLE): 1 + L + 1 cycles.
- Maximum countable rate: one edge per 2 clk cycles (f_clk/2). Faster input aliases; this is not detected.
- rst takes priority over everything, including a terminal cycle. The window in progress is discarded and no valid is issued.
- Gate counter width is $clog2(GATE_CYCLES+1). Division by 10 and 100 is constant, computed at elaboration.

## Structure
- freq_meter_pkg holds:
  - the state enum (IDLE, GATE)
  - range encodings RANGE_X1, RANGE_X10, RANGE_X100
  - the 4-bit bcd_digit_t typedef
  - a function mapping range to divisor
- Sub-module bcd_counter:
  - parameter: DIGITS
  - inputs: clk, rst, clr, inc
  - outputs: count, ovf, next_count (combinational count+inc, used for the terminal-cycle latch)
- Top level (bcd_freq_meter) contains the synchroniser, edge detector, gate counter, FSM and output registers.

## Test plan
Bench uses GATE_CYCLES=1000.
- Basic count: sig_in period 10 clk, range=0, enable=1 → every 1000 cycles valid pulses once; bcd=0x00000100, overflow=0, range_used=0.
- Short range: sig_in period 2, range=2 (L=10) → bcd=0x00000005 on every valid; range=3 gives the same, with range_used=2.
- Overflow: DIGITS=2, sig_in period 2, range=0 (500 edges) → bcd=0x99, overflow=1. Then sig_in period 100 → next-but-one valid gives bcd=0x10, overflow=0.
- Window boundary: a single edge placed in the terminal cycle, then one in the first cycle of the next window → counts 1 and 1; no edge lost or double-counted.
- Abort/resume: enable drops at cycle 500 of a window → no valid, outputs hold. Re-enable → first valid arrives 1002 cycles later with a full-window count.
- Reset: rst asserted 1 cycle at cycle 999 of a window → all outputs 0, no valid. Range change mid-window takes effect only in the next window's range_used.
